// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (I) and load/store (D).
// Grant is same-cycle with mem_gnt_i, and the response passes straight through. Only one access is outstanding.
// D has fixed priority. I is forced after STARVE_LIMIT consecutive contested D wins. Requesters hold until granted.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    i_req_i,
    input  logic [ADDR_WIDTH-1:0]   i_addr_i,
    output logic                    i_gnt_o,
    output logic                    i_rvalid_o,
    output logic [DATA_WIDTH-1:0]   i_rdata_o,
    input  logic                    d_req_i,
    input  logic                    d_we_i,
    input  logic [DATA_WIDTH/8-1:0] d_be_i,
    input  logic [ADDR_WIDTH-1:0]   d_addr_i,
    input  logic [DATA_WIDTH-1:0]   d_wdata_i,
    output logic                    d_gnt_o,
    output logic                    d_rvalid_o,
    output logic [DATA_WIDTH-1:0]   d_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    err_o
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;   // 1 = D owns the outstanding access
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             err_q, err_d;

    logic idle, sel_i, fire, resp;

    // Reset gating keeps every request and grant low while reset is asserted.
    assign idle      = (state_q == IDLE) && rst_ni;
    assign sel_i     = i_req_i && (!d_req_i || (starve_cnt_q == CNT_MAX));
    assign mem_req_o = idle && (i_req_i || d_req_i);
    assign fire      = mem_req_o && mem_gnt_i;
    assign i_gnt_o   = fire && sel_i;
    assign d_gnt_o   = fire && !sel_i;

    assign mem_we_o    = mem_req_o && !sel_i && d_we_i;
    assign mem_be_o    = !mem_req_o ? '0 : (sel_i ? {BE_W{1'b1}} : d_be_i);
    assign mem_addr_o  = !mem_req_o ? '0 : (sel_i ? i_addr_i : d_addr_i);
    assign mem_wdata_o = (mem_req_o && !sel_i) ? d_wdata_i : '0;

    assign resp       = (state_q != IDLE) && mem_rvalid_i;
    assign i_rvalid_o = resp && !owner_q;
    assign d_rvalid_o = resp && owner_q;
    assign i_rdata_o  = i_rvalid_o ? mem_rdata_i : '0;
    assign d_rdata_o  = d_rvalid_o ? mem_rdata_i : '0;
    assign err_o      = err_q;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        err_d        = err_q;
        case (state_q)
            IDLE: begin
                if (mem_rvalid_i) err_d = 1'b1;
                if (fire) begin
                    state_d = sel_i ? WAIT_I : WAIT_D;
                    owner_d = !sel_i;
                end
            end
            WAIT_I, WAIT_D: begin
                if (mem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (i_gnt_o) begin
            starve_cnt_d = '0;
        end else if (d_gnt_o && i_req_i && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
        end
    end

endmodule
